line_split_unit: RTL and testbench

Sequential successor to the combinational line-alignment logic in the coalescing path. It accepts one byte-granular request (addr, size, tag) over a valid/ready handshake and emits one line-aligned memory transaction per LINE_BYTES line touched. Each transaction carries the in-line offset, the byte count and first/last markers. It sits between the warp coalescer and the L1/L2 request queue, and absorbs downstream backpressure.

---
 rtl/line_split_unit.sv | 212 +++++++++++++++++++++
 tb/tb_line_split_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_split_unit.sv
`default_nettype none
// ============================================================================
// Module   : line_split_unit
// Purpose  : Splits one byte-granular request (addr, size, tag) into one
//            line-aligned memory transaction per LINE_BYTES line touched.
//            Each transaction carries the in-line offset, the byte count and
//            first/last markers. A one-entry output register absorbs
//            downstream backpressure.
// Ports    : clk, rst_n                      clock, async active-low reset
//            req_valid/req_ready             request handshake
//            req_addr/req_size/req_tag       request payload
//            txn_valid/txn_ready             transaction handshake
//            txn_addr/txn_offset/txn_bytes   line base, first byte, count
//            txn_first/txn_last/txn_tag      markers and request tag
//            zero_drop                       pulse after a size-0 request
// Options  : LINE_SPLIT_STATS_EN adds the saturating stat_reqs, stat_txns and
//            stat_cross counters.
// Revision : 1.0 - initial release
// ============================================================================
module line_split_unit #(
    parameter int ADDR_WIDTH = 64,
    parameter int LINE_BYTES = 128,
    parameter int SIZE_WIDTH = 32,
    parameter int TAG_WIDTH  = 8,
    localparam int LOG_LINE  = $clog2(LINE_BYTES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [SIZE_WIDTH-1:0] req_size,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  txn_valid,
    input  logic                  txn_ready,
    output logic [ADDR_WIDTH-1:0] txn_addr,
    output logic [LOG_LINE-1:0]   txn_offset,
    output logic [LOG_LINE:0]     txn_bytes,
    output logic                  txn_first,
    output logic                  txn_last,
    output logic [TAG_WIDTH-1:0]  txn_tag,
    output logic                  zero_drop
`ifdef LINE_SPLIT_STATS_EN
    ,
    output logic [31:0]           stat_reqs,
    output logic [31:0]           stat_txns,
    output logic [31:0]           stat_cross
`endif
);

    // Common width for all byte-count comparisons, wide enough for both a
    // full request size and the value LINE_BYTES itself.
    localparam int CW = (SIZE_WIDTH > LOG_LINE + 1) ? SIZE_WIDTH : LOG_LINE + 1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SPLIT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [LOG_LINE-1:0]    offset_q, offset_d;
    logic [LOG_LINE:0]      bytes_q, bytes_d;
    logic                   first_q, first_d;
    logic                   last_q, last_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
    logic [SIZE_WIDTH-1:0]  rem_q, rem_d;
    logic                   zero_drop_q, zero_drop_d;

    // First transaction: bytes = min(size, LINE_BYTES - offset)
    logic [LOG_LINE:0]      w_room;
    logic [CW-1:0]          w_size_x;
    logic [CW-1:0]          w_room_x;
    logic [CW-1:0]          w_first_x;
    logic [SIZE_WIDTH-1:0]  w_rem_first;

    // Follow-on transaction: bytes = min(remaining, LINE_BYTES)
    logic [CW-1:0]          w_rem_x;
    logic [CW-1:0]          w_line_x;
    logic [CW-1:0]          w_next_x;
    logic [SIZE_WIDTH-1:0]  w_rem_next;

    always_comb begin
        w_room      = (LOG_LINE + 1)'(LINE_BYTES) - {1'b0, req_addr[LOG_LINE-1:0]};
        w_size_x    = CW'(req_size);
        w_room_x    = CW'(w_room);
        w_first_x   = (w_size_x < w_room_x) ? w_size_x : w_room_x;
        w_rem_first = req_size - SIZE_WIDTH'(w_first_x);

        w_rem_x     = CW'(rem_q);
        w_line_x    = CW'(LINE_BYTES);
        w_next_x    = (w_rem_x < w_line_x) ? w_rem_x : w_line_x;
        w_rem_next  = rem_q - SIZE_WIDTH'(w_next_x);
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        offset_d    = offset_q;
        bytes_d     = bytes_q;
        first_d     = first_q;
        last_d      = last_q;
        tag_d       = tag_q;
        rem_d       = rem_q;
        zero_drop_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    tag_d = req_tag;
                    if (req_size == '0) begin
                        zero_drop_d = 1'b1;
                    end else begin
                        state_d  = S_SPLIT;
                        addr_d   = {req_addr[ADDR_WIDTH-1:LOG_LINE], {LOG_LINE{1'b0}}};
                        offset_d = req_addr[LOG_LINE-1:0];
                        bytes_d  = (LOG_LINE + 1)'(w_first_x);
                        first_d  = 1'b1;
                        rem_d    = w_rem_first;
                        last_d   = (w_rem_first == '0);
                    end
                end
            end
            S_SPLIT: begin
                if (txn_ready) begin
                    if (last_q) begin
                        state_d = S_IDLE;
                    end else begin
                        // Wraps naturally modulo 2^ADDR_WIDTH.
                        addr_d   = addr_q + ADDR_WIDTH'(LINE_BYTES);
                        offset_d = '0;
                        first_d  = 1'b0;
                        bytes_d  = (LOG_LINE + 1)'(w_next_x);
                        rem_d    = w_rem_next;
                        last_d   = (w_rem_next == '0);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            offset_q    <= '0;
            bytes_q     <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            tag_q       <= '0;
            rem_q       <= '0;
            zero_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            offset_q    <= offset_d;
            bytes_q     <= bytes_d;
            first_q     <= first_d;
            last_q      <= last_d;
            tag_q       <= tag_d;
            rem_q       <= rem_d;
            zero_drop_q <= zero_drop_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign txn_valid  = (state_q == S_SPLIT);
    assign txn_addr   = addr_q;
    assign txn_offset = offset_q;
    assign txn_bytes  = bytes_q;
    assign txn_first  = first_q;
    assign txn_last   = last_q;
    assign txn_tag    = tag_q;
    assign zero_drop  = zero_drop_q;

`ifdef LINE_SPLIT_STATS_EN
    logic [31:0] reqs_q, txns_q, cross_q;
    logic        w_req_fire, w_txn_fire;

    assign w_req_fire = req_valid && req_ready;
    assign w_txn_fire = txn_valid && txn_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reqs_q  <= '0;
            txns_q  <= '0;
            cross_q <= '0;
        end else begin
            if (w_req_fire && (reqs_q != '1)) begin
                reqs_q <= reqs_q + 32'd1;
            end
            if (w_txn_fire && (txns_q != '1)) begin
                txns_q <= txns_q + 32'd1;
            end
            // A first transaction that is not also last means the request
            // spans more than one line.
            if (w_txn_fire && first_q && !last_q && (cross_q != '1)) begin
                cross_q <= cross_q + 32'd1;
            end
        end
    end

    assign stat_reqs  = reqs_q;
    assign stat_txns  = txns_q;
    assign stat_cross = cross_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_line_split_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_split_unit
// Purpose  : Self-checking bench for line_split_unit. Expected transactions
//            are derived from the byte interval [addr, addr+size) intersected
//            with each line it touches.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_split_unit;

    localparam int AW = 64;
    localparam int LB = 128;
    localparam int SW = 32;
    localparam int TW = 8;
    localparam int LL = 7;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [SW-1:0] req_size;
    logic [TW-1:0] req_tag;
    logic          txn_valid;
    logic          txn_ready;
    logic [AW-1:0] txn_addr;
    logic [LL-1:0] txn_offset;
    logic [LL:0]   txn_bytes;
    logic          txn_first;
    logic          txn_last;
    logic [TW-1:0] txn_tag;
    logic          zero_drop;

    line_split_unit #(
        .ADDR_WIDTH (AW),
        .LINE_BYTES (LB),
        .SIZE_WIDTH (SW),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_tag    (req_tag),
        .txn_valid  (txn_valid),
        .txn_ready  (txn_ready),
        .txn_addr   (txn_addr),
        .txn_offset (txn_offset),
        .txn_bytes  (txn_bytes),
        .txn_first  (txn_first),
        .txn_last   (txn_last),
        .txn_tag    (txn_tag),
        .zero_drop  (zero_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        int unsigned   off;
        int unsigned   bytes;
        bit            first;
        bit            last;
        logic [TW-1:0] tag;
    } txn_t;

    txn_t exp_q[$];
    txn_t gen_q[$];
    bit   zd_exp;
    int   hs_cnt;
    int   zd_seen;
    int   mode;          // 0 random ready, 1 ready held high, 2 driven by main
    int   n_tests;
    int   n_fail;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every line intersecting [addr, addr+size) yields one transaction whose
    // bytes are exactly the intersection. 66-bit math keeps the end address
    // exact across the top of the address space.
    task automatic model_gen(input logic [AW-1:0] a, input logic [SW-1:0] sz, input logic [TW-1:0] tg);
        logic [65:0] s, e, lb, lo, hi;
        txn_t t;
        bit first;
        gen_q.delete();
        s     = {2'b00, a};
        e     = s + {34'd0, sz};
        lb    = s & ~66'(LB - 1);
        first = 1'b1;
        while (lb < e) begin
            lo      = (s > lb) ? s : lb;
            hi      = (e < lb + 66'(LB)) ? e : lb + 66'(LB);
            t.a     = lb[AW-1:0];
            t.off   = 32'(lo - lb);
            t.bytes = 32'(hi - lo);
            t.first = first;
            t.last  = (lb + 66'(LB) >= e);
            t.tag   = tg;
            gen_q.push_back(t);
            first   = 1'b0;
            lb      = lb + 66'(LB);
        end
    endtask

    // Compare process: outputs are checked on every falling edge, then the
    // model advances by whatever handshakes the next rising edge will see.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_txn_valid", txn_valid, 0);
            chk("rst_req_ready", req_ready, 1);
            chk("rst_zero_drop", zero_drop, 0);
            chk("rst_txn_addr", txn_addr, 0);
            chk("rst_txn_offset", txn_offset, 0);
            chk("rst_txn_bytes", txn_bytes, 0);
            chk("rst_txn_first", txn_first, 0);
            chk("rst_txn_last", txn_last, 0);
            chk("rst_txn_tag", txn_tag, 0);
            exp_q.delete();
            zd_exp = 1'b0;
        end else begin
            chk("req_ready", req_ready, exp_q.size() == 0);
            chk("txn_valid", txn_valid, exp_q.size() != 0);
            chk("zero_drop", zero_drop, zd_exp);
            if (zero_drop) zd_seen++;
            if (txn_valid && exp_q.size() != 0) begin
                chk("txn_addr", txn_addr, exp_q[0].a);
                chk("txn_offset", txn_offset, exp_q[0].off);
                chk("txn_bytes", txn_bytes, exp_q[0].bytes);
                chk("txn_first", txn_first, exp_q[0].first);
                chk("txn_last", txn_last, exp_q[0].last);
                chk("txn_tag", txn_tag, exp_q[0].tag);
            end
            zd_exp = 1'b0;
            if (txn_valid && txn_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                hs_cnt++;
            end
            if (req_valid && req_ready) begin
                if (req_size == '0) begin
                    zd_exp = 1'b1;
                end else begin
                    model_gen(req_addr, req_size, req_tag);
                    foreach (gen_q[i]) exp_q.push_back(gen_q[i]);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (mode == 0) txn_ready = (($urandom % 4) != 0);
        else if (mode == 1) txn_ready = 1'b1;
    end

    // Called at posedge+1; returns at posedge+1 just after acceptance.
    task automatic send(input logic [AW-1:0] a, input logic [SW-1:0] sz,
                        input logic [TW-1:0] tg, output int waited);
        req_valid = 1'b1;
        req_addr  = a;
        req_size  = sz;
        req_tag   = tg;
        waited    = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            waited++;
            if (waited > 3000) begin
                chk("req_accept_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!(exp_q.size() == 0 && req_ready)) begin
            @(posedge clk);
            #1;
            k++;
            if (k > 5000) begin
                chk("idle_timeout", 1, 0);
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          w;
    int          h0;
    logic [63:0] snap_a;
    logic [63:0] snap_f;
    int unsigned pin_bytes[4];
    int unsigned pin_addr_lo[4];

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        hs_cnt    = 0;
        zd_seen   = 0;
        zd_exp    = 1'b0;
        mode      = 2;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_size  = '0;
        req_tag   = '0;
        txn_ready = 1'b0;

        // Pin the model with hand-computed results.
        pin_bytes   = '{112, 128, 128, 32};
        pin_addr_lo = '{32'h1000, 32'h1080, 32'h1100, 32'h1180};
        model_gen(64'h1010, 400, 8'h00);
        chk("pin400_count", gen_q.size(), 4);
        if (gen_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("pin400_bytes", gen_q[i].bytes, pin_bytes[i]);
                chk("pin400_addr", gen_q[i].a, 64'(pin_addr_lo[i]));
            end
            chk("pin400_off", gen_q[0].off, 16);
            chk("pin400_last", gen_q[3].last, 1);
        end
        model_gen(64'hFFFF_FFFF_FFFF_FFF0, 32, 8'h00);
        chk("pinwrap_count", gen_q.size(), 2);
        if (gen_q.size() == 2) begin
            chk("pinwrap_a0", gen_q[0].a, 64'hFFFF_FFFF_FFFF_FF80);
            chk("pinwrap_off0", gen_q[0].off, 32'h70);
            chk("pinwrap_b0", gen_q[0].bytes, 16);
            chk("pinwrap_a1", gen_q[1].a, 64'h0);
            chk("pinwrap_b1", gen_q[1].bytes, 16);
        end
        model_gen(64'h107C, 8, 8'h00);
        chk("pin8_count", gen_q.size(), 2);

        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        mode      = 1;
        txn_ready = 1'b1;

        // Single full line, one transaction with first and last.
        send(64'h1000, 128, 8'h11, w);
        chk("s1_valid", txn_valid, 1);
        chk("s1_ready_low", req_ready, 0);
        @(posedge clk);
        #1;
        chk("s1_ready_back", req_ready, 1);
        wait_idle();

        // Two transactions across a line boundary.
        send(64'h107C, 8, 8'h12, w);
        wait_idle();

        // Four transactions, back to back.
        send(64'h1010, 400, 8'h13, w);
        wait_idle();

        // Same request with a three-cycle stall on the second transaction.
        mode = 2;
        h0   = hs_cnt;
        send(64'h1010, 400, 8'h14, w);
        @(posedge clk);
        #1;
        txn_ready = 1'b0;
        snap_a = txn_addr;
        snap_f = {txn_offset, txn_bytes, txn_first, txn_last, txn_tag};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_addr", txn_addr, snap_a);
            chk("stall_fields", {txn_offset, txn_bytes, txn_first, txn_last, txn_tag}, snap_f);
            chk("stall_req_ready", req_ready, 0);
        end
        chk("stall_second_addr", snap_a, 64'h1080);
        @(posedge clk);
        #1;
        txn_ready = 1'b1;
        mode      = 1;
        wait_idle();
        chk("stall_delivered", hs_cnt - h0, 4);

        // Size-0 request followed immediately by a real one.
        zd_seen = 0;
        send(64'h3000, 0, 8'h5A, w);
        chk("zero_accept_wait", w, 0);
        send(64'h2000, 64, 8'h15, w);
        chk("after_zero_accept_wait", w, 0);
        wait_idle();
        chk("zero_drop_cycles", zd_seen, 1);

        // Address wrap at the top of the space.
        send(64'hFFFF_FFFF_FFFF_FFF0, 32, 8'h16, w);
        wait_idle();

        // Reset in the middle of a four-transaction request.
        send(64'h1010, 400, 8'h17, w);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", txn_valid, 0);
        chk("midrst_ready", req_ready, 1);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_valid", txn_valid, 0);
        chk("postrst_ready", req_ready, 1);
        @(posedge clk);
        #1;

        // Randomized traffic with random backpressure.
        mode = 0;
        for (int n = 0; n < 200; n++) begin
            logic [AW-1:0] ra;
            logic [SW-1:0] rs;
            int            sel;
            repeat ($urandom % 3) begin
                @(posedge clk);
                #1;
            end
            sel = $urandom % 10;
            if (sel == 0) rs = 0;
            else if (sel <= 6) rs = SW'($urandom_range(1, 300));
            else if (sel <= 8) rs = SW'($urandom_range(1, 1200));
            else rs = SW'(LB * $urandom_range(1, 4));
            if (($urandom % 5) == 0) ra = {32'hFFFF_FFFF, 32'hFFFF_F000 | 32'($urandom % 4096)};
            else ra = {32'($urandom), 32'($urandom)};
            send(ra, rs, TW'($urandom), w);
        end
        mode = 1;
        wait_idle();
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
